// File: rtl/uart_mem_pkg.sv
// Shared definitions for the UART / byte-RAM datapath.
// Contents:
//   - FSM state encoding for ram_tx_streamer (3-bit, IDLE = 0)
//   - addr_inc(): address increment with wrap modulo the RAM depth
package uart_mem_pkg;

   localparam int unsigned STATE_W = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_READ  = 3'd1;
   localparam state_t ST_LATCH = 3'd2;
   localparam state_t ST_SEND  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   // Next RAM address; depth is a power of two so the modulo is a mask in hardware.
   function automatic int unsigned addr_inc(input int unsigned addr, input int unsigned depth);
      return (addr + 32'd1) % depth;
   endfunction

endpackage

// File: rtl/ram_tx_streamer.sv
// Drains a contiguous run of bytes from a dual-port byte RAM's synchronous
// read port to a UART transmitter over a valid/ready handshake.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a transfer (ignored while busy)
//   start_addr      first RAM address, sampled with start
//   count           number of bytes (0 allowed), sampled with start
//   rd_address      RAM read address (registered)
//   rd_data         RAM read data, valid one cycle after rd_address
//   tx_data         byte to the UART TX (registered)
//   tx_valid        tx_data valid
//   tx_ready        UART TX accepts the byte
//   busy            high in every non-IDLE state
//   done            one-cycle pulse at end of transfer
module ram_tx_streamer
   import uart_mem_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(DEPTH)-1:0]   start_addr,
   input  logic [$clog2(DEPTH):0]     count,
   output logic [$clog2(DEPTH)-1:0]   rd_address,
   input  logic [WIDTH-1:0]           rd_data,
   output logic [WIDTH-1:0]           tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned RW = AW + 1;

   state_t           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [RW-1:0]    remaining_q, remaining_d;
   logic [AW-1:0]    rd_address_q, rd_address_d;
   logic [WIDTH-1:0] tx_data_q, tx_data_d;
   logic             tx_valid_q, tx_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             handshake;

   assign handshake = tx_valid_q && tx_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = (count == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ:  state_d = ST_LATCH;
         ST_LATCH: state_d = ST_SEND;
         ST_SEND: begin
            if (handshake) begin
               state_d = (remaining_q == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values. rd_address is loaded on the edge that
   // enters READ so that it is presented to the RAM during the READ cycle.
   always_comb begin
      addr_d       = addr_q;
      remaining_d  = remaining_q;
      rd_address_d = rd_address_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start && (count != '0)) begin
               addr_d       = start_addr;
               remaining_d  = count;
               rd_address_d = start_addr;
            end
         end
         ST_LATCH: begin
            tx_data_d   = rd_data;
            tx_valid_d  = 1'b1;
            remaining_d = remaining_q - RW'(1);
            addr_d      = AW'(addr_inc(32'(addr_q), DEPTH));
         end
         ST_SEND: begin
            if (handshake) begin
               tx_valid_d = 1'b0;
               if (remaining_q != '0) begin
                  rd_address_d = addr_q;
               end
            end
         end
         default: ;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q       <= '0;
         remaining_q  <= '0;
         rd_address_q <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         rd_address_q <= rd_address_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign rd_address = rd_address_q;
   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_ram_tx_streamer.sv
// Self-checking bench for ram_tx_streamer: a table of directed transfers,
// a hand-written reset-abort sequence and randomized transfers, all checked
// against a queue of expected bytes taken from the bench's RAM image.
module tb_ram_tx_streamer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   count;
   logic [AW-1:0] rd_address;
   logic [7:0]    rd_data;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          busy;
   logic          done;

   logic [7:0] mem [DEPTH];

   int checks   = 0;
   int failures = 0;

   ram_tx_streamer #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .count      (count),
      .rd_address (rd_address),
      .rd_data    (rd_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM model
   always @(posedge clk) rd_data <= mem[rd_address];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // mode: 0 = tx_ready held high, 1 = random tx_ready, 2 = stall byte 2 for 10 cycles
   task automatic run_xfer(input int saddr, input int cnt, input int mode, input bit poke,
                           input int exp_first, input int exp_done, input string tag);
      logic [7:0] expq[$];
      logic [7:0] prev_d;
      logic [7:0] e;
      int  cyc, first, done_cyc, stall, nbytes;
      bit  prev_v, prev_hs, fin;
      for (int i = 0; i < cnt; i++) expq.push_back(mem[(saddr + i) % DEPTH]);
      @(negedge clk);
      start      = 1'b1;
      start_addr = AW'(saddr);
      count      = (AW+1)'(cnt);
      tx_ready   = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      cyc      = 0;
      first    = -1;
      done_cyc = -1;
      stall    = 0;
      nbytes   = 0;
      prev_v   = 1'b0;
      prev_hs  = 1'b0;
      prev_d   = '0;
      fin      = 1'b0;
      while (!fin) begin
         cyc++;
         if (prev_v && !prev_hs) begin
            chk({tag, " valid_hold"}, int'(tx_valid), 1);
            chk({tag, " data_hold"}, int'(tx_data), int'(prev_d));
         end
         if (tx_valid && first < 0) first = cyc;
         if (done_cyc < 0) begin
            chk({tag, " busy_during"}, int'(busy), 1);
            if (done) begin
               done_cyc = cyc;
               chk({tag, " bytes_left_at_done"}, expq.size(), 0);
               if (exp_done >= 0) chk({tag, " done_cycle"}, cyc, exp_done);
               if (exp_first >= 0) chk({tag, " first_valid_cycle"}, first, exp_first);
               if (cnt == 0) chk({tag, " no_valid_on_zero"}, first, -1);
            end
         end else begin
            chk({tag, " busy_after_done"}, int'(busy), 0);
            chk({tag, " done_single"}, int'(done), 0);
            chk({tag, " valid_after_done"}, int'(tx_valid), 0);
            fin = 1'b1;
         end
         if (poke && cyc == 5) begin
            start      = 1'b1;
            start_addr = AW'(8);
            count      = (AW+1)'(3);
         end else begin
            start = 1'b0;
         end
         case (mode)
            1: tx_ready = 1'($urandom_range(0, 1));
            2: begin
               if (tx_valid && nbytes == 1 && stall < 10) begin
                  tx_ready = 1'b0;
                  stall++;
               end else begin
                  tx_ready = 1'b1;
               end
            end
            default: tx_ready = 1'b1;
         endcase
         prev_hs = tx_valid && tx_ready;
         prev_v  = tx_valid;
         prev_d  = tx_data;
         if (prev_hs) begin
            nbytes++;
            if (expq.size() == 0) begin
               chk({tag, " extra_byte"}, 1, 0);
            end else begin
               e = expq.pop_front();
               chk({tag, " byte"}, int'(tx_data), int'(e));
            end
         end
         if (!fin && cyc > 400) begin
            chk({tag, " timeout"}, cyc, 0);
            fin = 1'b1;
         end
         if (!fin) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
   endtask

   typedef struct {
      int    saddr;
      int    cnt;
      int    mode;
      bit    poke;
      bit    wrap_img;
      int    exp_first;
      int    exp_done;
      string tag;
   } vec_t;

   vec_t vecs[8];

   task automatic base_image();
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(32'hA0 + i);
   endtask

   initial begin
      bit saw_done, saw_valid;

      vecs[0] = '{0,  4,  0, 1'b0, 1'b0, 3,  13, "basic4"};
      vecs[1] = '{14, 4,  0, 1'b0, 1'b1, 3,  13, "wrap"};
      vecs[2] = '{0,  4,  2, 1'b0, 1'b0, 3,  23, "backpressure"};
      vecs[3] = '{0,  0,  0, 1'b0, 1'b0, -1, 1,  "count0"};
      vecs[4] = '{0,  4,  0, 1'b1, 1'b0, 3,  13, "start_busy"};
      vecs[5] = '{5,  1,  0, 1'b0, 1'b0, 3,  4,  "single"};
      vecs[6] = '{10, 20, 0, 1'b0, 1'b0, 3,  61, "long_wrap"};
      vecs[7] = '{3,  31, 0, 1'b0, 1'b0, 3,  94, "max_count"};

      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      count      = '0;
      tx_ready   = 1'b0;
      base_image();
      repeat (3) @(posedge clk);
      #1;
      chk("reset rd_address", int'(rd_address), 0);
      chk("reset tx_data", int'(tx_data), 0);
      chk("reset tx_valid", int'(tx_valid), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      rst = 1'b0;

      for (int v = 0; v < 8; v++) begin
         base_image();
         if (vecs[v].wrap_img) begin
            mem[14] = 8'hEE;
            mem[15] = 8'hFF;
            mem[0]  = 8'h00;
            mem[1]  = 8'h11;
         end
         run_xfer(vecs[v].saddr, vecs[v].cnt, vecs[v].mode, vecs[v].poke,
                  vecs[v].exp_first, vecs[v].exp_done, vecs[v].tag);
      end

      // Reset while byte 2 of 4 is being offered: abort with no done pulse.
      base_image();
      @(negedge clk);
      start      = 1'b1;
      start_addr = '0;
      count      = 5'd4;
      tx_ready   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_abort byte2_valid", int'(tx_valid), 1);
      chk("rst_abort byte2_data", int'(tx_data), 'hA1);
      rst      = 1'b1;
      tx_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_abort rd_address", int'(rd_address), 0);
      chk("rst_abort tx_data", int'(tx_data), 0);
      chk("rst_abort tx_valid", int'(tx_valid), 0);
      chk("rst_abort busy", int'(busy), 0);
      chk("rst_abort done", int'(done), 0);
      saw_done  = 1'b0;
      saw_valid = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
         if (tx_valid || busy) saw_valid = 1'b1;
      end
      chk("rst_abort no_done", int'(saw_done), 0);
      chk("rst_abort stays_idle", int'(saw_valid), 0);
      run_xfer(0, 1, 0, 1'b0, 3, 4, "post_rst");

      // Randomized transfers against the RAM-image queue model.
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
         run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 31)),
                  1, 1'b0, -1, -1, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_tx_streamer.md
# ram_tx_streamer

Reads a contiguous run of bytes from the dual-port byte RAM's read port and presents them one at a time to the UART transmitter's byte input over a valid/ready handshake. It is the reader side of the RAM: a host or receiver path fills the buffer through the write port, and this block drains it to the serial line on command. The block accounts for the RAM's 1-cycle synchronous read latency. Addresses wrap modulo DEPTH.

## Interface
- WIDTH, 8: data width; must equal the RAM width.
- DEPTH, 16: RAM depth, power of two; AW = $clog2(DEPTH).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse to begin a transfer; sampled only in IDLE.
- start_addr  in  AW  first RAM address; sampled with start.
- count  in  AW+1  number of bytes, 0..2^(AW+1)-1; sampled with start.
- rd_address  out  AW  to the RAM read address; registered.
- rd_data  in  WIDTH  from the RAM read data; valid 1 cycle after rd_address.
- tx_data  out  WIDTH  byte to the UART TX; registered.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  the UART TX accepts the byte.
- busy  out  1  high in every non-IDLE state.
- done  out  1  1-cycle pulse when a transfer completes.

## Operation
- FSM states: IDLE, READ, LATCH, SEND, DONE.
- IDLE: if start=1 and count≠0, load addr←start_addr and remaining←count, then go to READ. If start=1 and count=0, go to DONE. No byte is emitted in that case.
- READ: rd_address=addr for this cycle, and the RAM samples it at the end of the cycle. Go to LATCH.
- LATCH: rd_data now holds mem[addr]. Register it into tx_data, set tx_valid=1, decrement remaining, and advance addr to (addr+1) mod DEPTH. Go to SEND.
- SEND: hold tx_data and tx_valid steady until tx_valid&&tx_ready. On the handshake, drop tx_valid. If remaining=0, go to DONE; otherwise go to READ.
- DONE: assert done=1 for one cycle, then go to IDLE.
- tx_valid never deasserts without a handshake, except on rst. tx_data never changes while tx_valid=1.
- start is ignored whenever busy=1. It is not queued.
- Transfers with count>DEPTH wrap through the RAM repeatedly, in address order.
- Writes to the RAM during a transfer are not blocked. A byte is read at its READ cycle, so a write to an address that has not been read yet is seen; a write to an address that has already been read is not.
- Reset: every output is 0 and the state is IDLE (rd_address=0, tx_data=0, tx_valid=0, busy=0, done=0). A reset mid-transfer aborts immediately: tx_valid drops, no done pulse is generated, and the remaining bytes are discarded.

## Timing
- start is sampled at edge 0. READ occupies cycle 1, LATCH cycle 2, and tx_valid=1 from cycle 3.
- Per byte: the handshake at cycle n leads to READ at n+1 and tx_valid for the next byte at n+3. With tx_ready tied high, throughput is 1 byte per 3 cycles.
- The last handshake at cycle n gives done=1 in cycle n+1 and busy=0 from cycle n+2. A new start is accepted from cycle n+2.
- With count=0: start at edge 0 gives done=1 in cycle 1 and IDLE in cycle 2.
- rd_address holds its last value in every state except READ.

## Structure
- A shared package, uart_mem_pkg, holds:
  - the FSM state encoding (3-bit localparams, IDLE=0);
  - an address-increment-with-wrap helper function.
- No sub-module: the RAM and the UART TX are instantiated by the parent and wired to this block's ports. The FSM, address register and remaining counter all live in this module.

## Test plan
- Preload mem[0..3]=A0,A1,A2,A3. Pulse start with start_addr=0, count=4 and tx_ready held 1. Expected:
  - bytes A0,A1,A2,A3 in order;
  - first tx_valid at cycle 3, then one byte every 3 cycles;
  - done pulses once, 1 cycle after the last handshake.
- Wrap-around: start_addr=14, count=4, DEPTH=16, with mem[14]=EE, mem[15]=FF, mem[0]=00, mem[1]=11 -> bytes EE,FF,00,11.
- Backpressure: tx_ready=0 for 10 cycles on byte 2, then 1 -> tx_valid and tx_data stay stable all 10 cycles, and no byte is lost or duplicated.
- count=0 -> done in cycle 1, tx_valid never asserted, busy high for exactly 1 cycle.
- start pulsed again while busy (start_addr=8) -> ignored; the original sequence completes unchanged.
- rst asserted in SEND of byte 2 of 4 -> next cycle all outputs are 0, no done pulse. A new start with start_addr=0, count=1 then returns A0 normally.
